ofm_drain: RTL and testbench

- Output-drain stage directly downstream of the 32x32 systolic MAC array.
- On request, drives the array's per-column output-shift enables with the required column skew.
- Captures the HEIGHT partial sums that shift out of each column on ofm[w], and deskews them into a frame buffer.
- Emits the result row by row, all WIDTH columns in parallel, over a valid/ready stream to the writeback logic.

---
 rtl/ofm_drain.sv | 185 ++++++++++++++++++
 tb/tb_ofm_drain.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_drain.sv
//------------------------------------------------------------------------------
// ofm_drain
//
// Output-drain stage behind the HEIGHT x WIDTH systolic MAC array. A drain
// request skews the per-column shift enables across the array, captures the
// HEIGHT partial sums that shift out of every column into a frame buffer
// (undoing the column skew), then streams the frame out row by row, all
// WIDTH lanes per beat, over a valid/ready interface.
//
// Optional build macro:
//   OFM_SAT_EN - each output lane is signed-saturated from OWIDTH to QWIDTH
//                bits on emission (QWIDTH parameter only exists in this build).
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   drain_req   - start a drain (accepted only while busy=0)
//   busy        - drain in progress (acceptance .. last row handshake)
//   en_o        - per-column output-shift enable to the array
//   clr_o       - per-column accumulator clear to the array
//   ofm         - per-column OWIDTH-bit signed results from the array
//   out_valid   - row beat valid
//   out_ready   - downstream accepts the beat
//   out_row     - row index of the current beat
//   out_data    - row beat, WIDTH lanes (QWIDTH or OWIDTH bits each)
//   out_last    - asserted with row HEIGHT-1
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module ofm_drain #(
    parameter int HEIGHT = 32,
    parameter int WIDTH  = 32,
    parameter int OWIDTH = 24,
    parameter int OLAT   = 2
`ifdef OFM_SAT_EN
    ,
    parameter int QWIDTH = 8
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             drain_req,
    output logic                             busy,
    output logic [WIDTH-1:0]                 en_o,
    output logic [WIDTH-1:0]                 clr_o,
    input  logic [WIDTH-1:0][OWIDTH-1:0]     ofm,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(HEIGHT)-1:0]        out_row,
`ifdef OFM_SAT_EN
    output logic [WIDTH-1:0][QWIDTH-1:0]     out_data,
`else
    output logic [WIDTH-1:0][OWIDTH-1:0]     out_data,
`endif
    output logic                             out_last
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam int TW    = $clog2(WIDTH + OLAT + HEIGHT);
    // Last capture cycle: column WIDTH-1, sample HEIGHT-1.
    localparam int T_END = WIDTH - 1 + OLAT + HEIGHT - 1;
    // Row r becomes presentable at t = FIRST + r.
    localparam int FIRST = WIDTH + OLAT;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    t_q, t_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [OWIDTH-1:0] buf_q [HEIGHT][WIDTH];
    logic [OWIDTH-1:0] buf_d [HEIGHT][WIDTH];

    logic [31:0] t_u;
    logic [31:0] row_u;
    logic        hs;
    logic        last_row;

    assign t_u      = 32'(t_q);
    assign row_u    = 32'(row_q);
    assign hs       = out_valid & out_ready;
    assign last_row = (row_q == ROW_W'(HEIGHT - 1));
    assign busy     = (state_q != S_IDLE);

`ifdef OFM_SAT_EN
    function automatic logic [QWIDTH-1:0] sat_lane(input logic [OWIDTH-1:0] v);
        logic [OWIDTH-QWIDTH:0] top;
        top = v[OWIDTH-1:QWIDTH-1];
        // In range exactly when every bit above the target sign bit matches it.
        if (top == '0 || top == '1)
            sat_lane = v[QWIDTH-1:0];
        else if (v[OWIDTH-1])
            sat_lane = {1'b1, {(QWIDTH-1){1'b0}}};
        else
            sat_lane = {1'b0, {(QWIDTH-1){1'b1}}};
    endfunction
`endif

    // Control FSM
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (drain_req) begin
                    state_d = S_CAPTURE;
                    t_d     = '0;
                    row_d   = '0;
                end
            end
            S_CAPTURE: begin
                t_d = t_q + TW'(1);
                if (hs)
                    row_d = row_q + ROW_W'(1);
                if (t_q == TW'(T_END))
                    state_d = (hs && last_row) ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: begin
                if (hs) begin
                    row_d = row_q + ROW_W'(1);
                    if (last_row)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Column-skewed enables/clears and deskewing buffer writes
    always_comb begin
        en_o  = '0;
        clr_o = '0;
        buf_d = buf_q;
        if (state_q == S_CAPTURE) begin
            for (int unsigned w = 0; w < WIDTH; w++) begin
                en_o[w]  = (t_u >= w) && (t_u < w + HEIGHT);
                clr_o[w] = (t_u == w + HEIGHT);
                // Column w's sample k arrives at t = w + OLAT + k; store as row k.
                if ((t_u >= w + OLAT) && (t_u < w + OLAT + HEIGHT))
                    buf_d[ROW_W'(t_u - w - OLAT)][w] = ofm[w];
            end
        end
    end

    // Row emission; outputs forced to zero whenever no beat is presented
    always_comb begin
        out_valid = 1'b0;
        out_row   = '0;
        out_last  = 1'b0;
        out_data  = '0;
        if (state_q == S_FLUSH)
            out_valid = 1'b1;
        else if (state_q == S_CAPTURE)
            out_valid = (t_u >= FIRST + row_u);
        if (out_valid) begin
            out_row  = row_q;
            out_last = last_row;
            for (int unsigned w = 0; w < WIDTH; w++) begin
`ifdef OFM_SAT_EN
                out_data[w] = sat_lane(buf_q[row_q][w]);
`else
                out_data[w] = buf_q[row_q][w];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            row_q   <= row_d;
        end
    end

    // Frame contents need no reset: nothing is emitted before it is written.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_ofm_drain.sv
`timescale 1ns/1ps
module tb_ofm_drain;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int OL = 2;
    localparam int OW = 24;
`ifdef OFM_SAT_EN
    localparam int DW = 8;
`else
    localparam int DW = 24;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   drain_req = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   busy;
    logic [W-1:0]           en_o;
    logic [W-1:0]           clr_o;
    logic [W-1:0][OW-1:0]   ofm;
    logic                   out_valid;
    logic [1:0]             out_row;
    logic [W-1:0][DW-1:0]   out_data;
    logic                   out_last;

    always #5 clk = ~clk;

    ofm_drain #(
        .HEIGHT (H),
        .WIDTH  (W),
        .OWIDTH (OW),
        .OLAT   (OL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .drain_req (drain_req),
        .busy      (busy),
        .en_o      (en_o),
        .clr_o     (clr_o),
        .ofm       (ofm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // ---------------- array model ----------------
    int model_base = 0;
    int model_mode = 0;
    int special [W] = '{300, -300, 100, -128};
    logic dl_v [W][OL];
    int   dl_k [W][OL];
    int   run_k [W];
    logic prev_en [W];

    function automatic int lane_val(int k, int w);
        if (model_mode == 1) return special[w];
        return model_base + 16 * k + w;
    endfunction

    function automatic longint exp_lane(int k, int w);
        longint v;
        v = lane_val(k, w);
`ifdef OFM_SAT_EN
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`endif
        return v;
    endfunction

    // At the negedge of cycle c: present the sample requested by en_o at c-OL,
    // then record this cycle's enables.
    always @(negedge clk) begin
        for (int w = 0; w < W; w++) begin
            int k;
            if (dl_v[w][OL-1]) ofm[w] = OW'(lane_val(dl_k[w][OL-1], w));
            else               ofm[w] = 24'h5A5A5A;
            for (int i = OL - 1; i > 0; i--) begin
                dl_v[w][i] = dl_v[w][i-1];
                dl_k[w][i] = dl_k[w][i-1];
            end
            k = prev_en[w] ? run_k[w] + 1 : 0;
            if (en_o[w] === 1'b1) begin
                dl_v[w][0] = 1'b1;
                dl_k[w][0] = k;
                run_k[w]   = k;
                prev_en[w] = 1'b1;
            end else begin
                dl_v[w][0] = 1'b0;
                prev_en[w] = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    typedef struct {
        int     row;
        logic   last;
        longint d [W];
    } beat_t;
    beat_t sb [$];

    typedef struct {
        int base;
        int mode;
        int rdy_from;
        int req_a;
        int req_b;
        int exp_first;
        int exp_idle;
    } vec_t;
    vec_t vecs [5];

    task automatic run_drain(input vec_t v, input string tag);
        int   beats;
        bit   done;
        bit   held;
        int   h_row;
        logic h_last;
        logic [W-1:0][DW-1:0] h_data;
        logic [W-1:0] e_en, e_clr;
        model_base = v.base;
        model_mode = v.mode;
        for (int r = 0; r < H; r++) begin
            beat_t b;
            b.row  = r;
            b.last = (r == H - 1);
            for (int w = 0; w < W; w++) b.d[w] = exp_lane(r, w);
            sb.push_back(b);
        end
        drain_req = 1'b1;
        @(negedge clk);
        drain_req = 1'b0;
        beats = 0; done = 0; held = 0;
        h_row = 0; h_last = 0; h_data = '0;
        for (int t = 0; t < 40 && !done; t++) begin
            out_ready = (t >= v.rdy_from);
            drain_req = (t == v.req_a || t == v.req_b);
            for (int w = 0; w < W; w++) begin
                e_en[w]  = (t >= w && t <= w + H - 1);
                e_clr[w] = (t == w + H);
            end
            chk($sformatf("%s en_o t=%0d", tag, t), en_o, e_en);
            chk($sformatf("%s clr_o t=%0d", tag, t), clr_o, e_clr);
            if (busy !== 1'b1) begin
                chk($sformatf("%s busy-fall t", tag), t, v.exp_idle);
                chk($sformatf("%s idle out_valid", tag), out_valid, 0);
                done = 1;
            end else begin
                chk($sformatf("%s out_valid t=%0d", tag, t), out_valid, (t >= W + OL + beats));
                if (held) begin
                    chk($sformatf("%s hold row t=%0d", tag, t), out_row, h_row);
                    chk($sformatf("%s hold last t=%0d", tag, t), out_last, h_last);
                    chk($sformatf("%s hold data t=%0d", tag, t), (out_data == h_data), 1);
                end
                held = 0;
                if (out_valid === 1'b1) begin
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            chk($sformatf("%s extra beat t=%0d", tag, t), 1, 0);
                        end else begin
                            beat_t b;
                            b = sb.pop_front();
                            chk($sformatf("%s beat time r%0d", tag, b.row), t, v.exp_first + beats);
                            chk($sformatf("%s out_row", tag), out_row, b.row);
                            chk($sformatf("%s out_last r%0d", tag, b.row), out_last, b.last);
                            for (int w = 0; w < W; w++)
                                chk($sformatf("%s data r%0d l%0d", tag, b.row, w),
                                    longint'($signed(out_data[w])), b.d[w]);
                        end
                        beats++;
                    end else begin
                        held = 1;
                        h_row = out_row; h_last = out_last; h_data = out_data;
                    end
                end
            end
            if (!done) @(negedge clk);
        end
        drain_req = 1'b0;
        out_ready = 1'b0;
        if (!done) chk($sformatf("%s timeout", tag), 0, 1);
        chk($sformatf("%s beat count", tag), beats, H);
        sb.delete();
        // No request may have been latched: stay idle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("%s post busy", tag), busy, 0);
            chk($sformatf("%s post en_o", tag), en_o, 0);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " en_o"}, en_o, 0);
        chk({tag, " clr_o"}, clr_o, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " out_last"}, out_last, 0);
        chk({tag, " out_row"}, out_row, 0);
        chk({tag, " out_data"}, (out_data == '0), 1);
    endtask

    initial begin
        ofm = '0;
        for (int w = 0; w < W; w++) begin
            prev_en[w] = 1'b0;
            run_k[w]   = 0;
            for (int i = 0; i < OL; i++) begin
                dl_v[w][i] = 1'b0;
                dl_k[w][i] = 0;
            end
        end
        //          base  mode rdy req_a req_b first idle
        vecs[0] = '{   0, 0,   0,  -1,   -1,   6,   10};
        vecs[1] = '{   0, 0,  12,  -1,   -1,  12,   16};
        vecs[2] = '{ 100, 0,   0,   2,    9,   6,   10};
        vecs[3] = '{   0, 1,   0,  -1,   -1,   6,   10};
        vecs[4] = '{-500, 0,   7,  -1,   -1,   7,   11};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("idle");

        for (int i = 0; i < 5; i++)
            run_drain(vecs[i], $sformatf("v%0d", i));

        // Reset mid-drain at t=4
        model_base = 0; model_mode = 0;
        drain_req = 1'b1;
        @(negedge clk);
        drain_req = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort en_o t=4", en_o, 4'b1110);
        chk("abort busy t=4", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("abort");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort quiet en_o", en_o, 0);
            chk("abort quiet valid", out_valid, 0);
            chk("abort quiet busy", busy, 0);
        end
        out_ready = 1'b0;
        run_drain(vecs[0], "fresh");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
